// File: rtl/ducq_nco_if.sv
// Sample-stream bundle for the quadrature NCO: tuning/phase controls in, signed cos/sin samples out.
// en/out_vld are valid-only strobes with no ready: every en is accepted, and exactly one out_vld pulse follows three cycles later.
interface ducq_nco_if #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 10
);
  logic [PHASE_W-1:0] fcw;
  logic               fcw_ld;
  logic [PHASE_W-1:0] ph_off;
  logic               ph_clr;
  logic               en;
  logic [OUT_W-1:0]   cos_o;
  logic [OUT_W-1:0]   sin_o;
  logic               out_vld;

  modport master (
    output fcw, fcw_ld, ph_off, ph_clr, en,
    input  cos_o, sin_o, out_vld
  );

  modport slave (
    input  fcw, fcw_ld, ph_off, ph_clr, en,
    output cos_o, sin_o, out_vld
  );
endinterface

// File: rtl/ducq_nco.sv
// Quadrature NCO: phase accumulator, quarter-wave cosine table with quadrant folding, 3-cycle latency.
// Define DUCQ_NCO_DITHER_EN to add LFSR phase dither below the table address; the cosine table is built at elaboration.
module ducq_nco #(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 9,
  parameter int OUT_W   = 10
) (
  input  logic         clk,
  input  logic         rst,
  ducq_nco_if.slave    bus
);
  localparam int N  = 2 ** LUT_AW;
  localparam int CW = OUT_W - 1;
  localparam int SH = PHASE_W - 2 - LUT_AW;

  // Entry k = round((2**(OUT_W-1)-1) * cos(pi/2 * (k+0.5)/N)); the half-step offset keeps the fold symmetric.
  logic [CW-1:0] rom [N];
  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam real ANG = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(N);
    localparam int  VAL = $rtoi(real'(2 ** (OUT_W - 1) - 1) * $cos(ANG) + 0.5);
    assign rom[k] = CW'(VAL);
  end

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] fcw_q;
  logic [PHASE_W-1:0] p;
  logic [PHASE_W-1:0] t;
  logic [LUT_AW+1:0]  t_hi;
  logic [1:0]         q1_q, q2_q;
  logic [LUT_AW-1:0]  a1_q;
  logic [CW-1:0]      ca_q, cb_q;
  logic [2:0]         v_q;
  logic [OUT_W-1:0]   cos_q, cos_d, sin_q, sin_d;
  logic [OUT_W-1:0]   xa, xb;

`ifdef DUCQ_NCO_DITHER_EN
  localparam int DW = (SH > 16) ? 16 : SH;
  logic [15:0] lfsr_q;
  logic        lfsr_fb;
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk) begin
    if (rst)          lfsr_q <= 16'hACE1;
    else if (bus.en)  lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end

  assign t = p + bus.ph_off + PHASE_W'(lfsr_q[DW-1:0]);
`else
  assign t = p + bus.ph_off;
`endif

  // Stage 0: phase of this sample and the accumulator update.
  always_comb begin
    p     = bus.ph_clr ? '0 : acc_q;
    acc_d = acc_q;
    if (bus.en)          acc_d = p + fcw_q;
    else if (bus.ph_clr) acc_d = '0;
  end

  assign t_hi = (LUT_AW + 2)'(t >> SH);

  always_comb begin
    xa    = {1'b0, ca_q};
    xb    = {1'b0, cb_q};
    cos_d = cos_q;
    sin_d = sin_q;
    if (v_q[1]) begin
      unique case (q2_q)
        2'd0: begin cos_d =  xa; sin_d =  xb; end
        2'd1: begin cos_d = -xb; sin_d =  xa; end
        2'd2: begin cos_d = -xa; sin_d = -xb; end
        default: begin cos_d =  xb; sin_d = -xa; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      fcw_q <= '0;
      q1_q  <= '0;
      a1_q  <= '0;
      q2_q  <= '0;
      ca_q  <= '0;
      cb_q  <= '0;
      v_q   <= '0;
      cos_q <= '0;
      sin_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (bus.fcw_ld) fcw_q <= bus.fcw;
      q1_q  <= t_hi[LUT_AW+1 -: 2];
      a1_q  <= t_hi[LUT_AW-1:0];
      q2_q  <= q1_q;
      // ~a is N-1-a: second read port serves the mirrored quarter.
      ca_q  <= rom[a1_q];
      cb_q  <= rom[~a1_q];
      v_q   <= {v_q[1:0], bus.en};
      cos_q <= cos_d;
      sin_q <= sin_d;
    end
  end

  assign bus.cos_o   = cos_q;
  assign bus.sin_o   = sin_q;
  assign bus.out_vld = v_q[2];
endmodule

// File: tb/tb_ducq_nco.sv
// Directed bench for ducq_nco: quarter/half-turn steps, offsets, clears, fcw reload timing, gaps and reset.
module tb_ducq_nco;
  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  ducq_nco_if #(.PHASE_W(32), .OUT_W(10)) bus ();

  ducq_nco #(.PHASE_W(32), .LUT_AW(9), .OUT_W(10)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected samples issued in the last three cycles, plus the value the outputs should hold.
  logic [9:0] pc [3];
  logic [9:0] ps [3];
  logic       pv [3];
  logic [9:0] hc, hs;

  localparam logic [31:0] F = 32'h4000_0000;

  task automatic chk(input string tag, input logic [9:0] ec, input logic [9:0] es, input logic ev);
    vecs++;
    assert (bus.out_vld === ev) else begin
      errs++;
      $error("FAIL %s out_vld got %b want %b", tag, bus.out_vld, ev);
    end
    vecs++;
    assert (bus.cos_o === ec) else begin
      errs++;
      $error("FAIL %s cos_o got %0d want %0d", tag, $signed(bus.cos_o), $signed(ec));
    end
    vecs++;
    assert (bus.sin_o === es) else begin
      errs++;
      $error("FAIL %s sin_o got %0d want %0d", tag, $signed(bus.sin_o), $signed(es));
    end
  endtask

  task automatic clr_pipe();
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pc[i] = '0;
      ps[i] = '0;
    end
    hc = '0;
    hs = '0;
  endtask

  task automatic do_reset(input string tag);
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.ph_clr = 1'b0;
    bus.fcw_ld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr_pipe();
    chk(tag, 10'd0, 10'd0, 1'b0);
    rst = 1'b0;
  endtask

  // Apply one cycle of inputs; the output seen afterwards belongs to the sample issued two calls earlier.
  task automatic smp(input logic e, input logic c, input logic ld, input logic [31:0] f,
                     input int ec, input int es, input string tag);
    bus.en     = e;
    bus.ph_clr = c;
    bus.fcw_ld = ld;
    bus.fcw    = f;
    @(posedge clk);
    @(negedge clk);
    pv[2] = pv[1]; pc[2] = pc[1]; ps[2] = ps[1];
    pv[1] = pv[0]; pc[1] = pc[0]; ps[1] = ps[0];
    pv[0] = e;     pc[0] = 10'(ec); ps[0] = 10'(es);
    if (pv[2]) begin
      hc = pc[2];
      hs = ps[2];
    end
    chk(tag, hc, hs, pv[2]);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3; i++) smp(1'b0, 1'b0, 1'b0, 32'h0, 0, 0, tag);
  endtask

  initial begin
    vecs       = 0;
    errs       = 0;
    rst        = 1'b1;
    bus.fcw    = '0;
    bus.fcw_ld = 1'b0;
    bus.ph_off = '0;
    bus.ph_clr = 1'b0;
    bus.en     = 1'b0;
    clr_pipe();
    @(negedge clk);
    do_reset("reset");

    // Quarter-turn steps with wrap-around of the accumulator.
    smp(1'b0, 1'b0, 1'b1, F, 0, 0, "load_q");
    for (int i = 0; i < 2; i++) begin
      smp(1'b1, 1'b0, 1'b0, 32'h0,  511,    1, "quarter0");
      smp(1'b1, 1'b0, 1'b0, 32'h0,   -1,  511, "quarter1");
      smp(1'b1, 1'b0, 1'b0, 32'h0, -511,   -1, "quarter2");
      smp(1'b1, 1'b0, 1'b0, 32'h0,    1, -511, "quarter3");
    end

    // Gapped en; outputs hold while out_vld is low.
    smp(1'b1, 1'b0, 1'b0, 32'h0,  511,    1, "gap_s0");
    smp(1'b0, 1'b0, 1'b0, 32'h0,    0,    0, "gap_g0");
    smp(1'b1, 1'b0, 1'b0, 32'h0,   -1,  511, "gap_s1");
    smp(1'b1, 1'b0, 1'b0, 32'h0, -511,   -1, "gap_s2");
    smp(1'b0, 1'b0, 1'b0, 32'h0,    0,    0, "gap_g1");
    drain("gap_hold");

    // Phase clear with and without en (acc = 3/4 turn here).
    smp(1'b1, 1'b0, 1'b0, 32'h0,    1, -511, "clr_pre");
    smp(1'b1, 1'b0, 1'b0, 32'h0,  511,    1, "clr_pre2");
    smp(1'b1, 1'b1, 1'b0, 32'h0,  511,    1, "clr_en_k");
    smp(1'b1, 1'b0, 1'b0, 32'h0,   -1,  511, "clr_en_k1");
    smp(1'b0, 1'b1, 1'b0, 32'h0,    0,    0, "clr_noen");
    smp(1'b1, 1'b0, 1'b0, 32'h0,  511,    1, "clr_noen_s");

    // fcw reload coinciding with en: old word for that step, new word afterwards.
    smp(1'b1, 1'b0, 1'b1, 32'h8000_0000, -1,  511, "ld_same");
    smp(1'b1, 1'b0, 1'b0, 32'h0,       -511,   -1, "ld_new0");
    smp(1'b1, 1'b0, 1'b0, 32'h0,        511,    1, "ld_new1");
    smp(1'b1, 1'b0, 1'b0, 32'h0,       -511,   -1, "ld_new2");

    // Static phase offsets with fcw = 0, including table-address boundaries.
    smp(1'b0, 1'b0, 1'b1, 32'h0, 0, 0, "load_zero");
    bus.ph_off = F;
    for (int i = 0; i < 3; i++) smp(1'b1, 1'b0, 1'b0, 32'h0, -1, 511, "off_q1");
    bus.ph_off = 32'h8000_0000;
    for (int i = 0; i < 3; i++) smp(1'b1, 1'b0, 1'b0, 32'h0, -511, -1, "off_half");
    bus.ph_off = 32'h2000_0000;
    smp(1'b1, 1'b0, 1'b0, 32'h0, 361, 362, "off_eighth");
    bus.ph_off = 32'h001F_FFFF;
    smp(1'b1, 1'b0, 1'b0, 32'h0, 511, 1, "off_trunc");
    bus.ph_off = 32'h0020_0000;
    smp(1'b1, 1'b0, 1'b0, 32'h0, 511, 2, "off_addr1");
    bus.ph_off = '0;
    drain("off_drain");

    // Reset with samples in flight, then fcw_r = 0 gives a constant phase.
    smp(1'b0, 1'b0, 1'b1, F, 0, 0, "load_q2");
    smp(1'b1, 1'b0, 1'b0, 32'h0,  511,   1, "flight0");
    smp(1'b1, 1'b0, 1'b0, 32'h0,   -1, 511, "flight1");
    smp(1'b1, 1'b0, 1'b0, 32'h0, -511,  -1, "flight2");
    do_reset("mid_reset");
    for (int i = 0; i < 4; i++) smp(1'b1, 1'b0, 1'b0, 32'h0, 511, 1, "post_rst");
    drain("post_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
